// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam int          PC_STEP  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the fetch unit's control, memory and decode-side signals.
// Latency: n/a (wiring only).
// Backpressure: imem_req_ready stalls requests, inst_ready stalls decode hand-off.
interface inst_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int IMEM_AW = 11
);
  logic               fetch_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rsp_valid;
  logic [INST_W-1:0]  imem_rsp_data;
  logic               inst_valid;
  logic               inst_ready;
  logic [INST_W-1:0]  inst;
  logic [ADDR_W-1:0]  inst_pc;
  logic               misalign_err;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, misalign_err
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, misalign_err
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush beats push/pop.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the caller must not push when full.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     empty,
  output logic                     full
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !full) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word requests, buffers {pc, inst} for decode.
// Latency: response in cycle N reaches inst_valid in cycle N+1 at the earliest (no bypass).
// Backpressure: requests stop once in-flight plus buffered reaches DEPTH; decode stalls via inst_ready.
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              IMEM_AW  = 11,
  parameter int              DEPTH    = 4,
  parameter logic [31:0]     RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);
  localparam int              CW      = cnt_w(DEPTH);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              misalign_q;
  entry_t            head;
  entry_t            push_dat;
  logic              redirect;
  logic              dropping;
  logic              req_valid;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target_pc;

  assign redirect  = bus.redirect_valid;
  assign dropping  = (drop_cnt != '0);
  assign target_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // Credit check covers both in-flight and buffered words, so the buffer can never overflow.
  assign req_valid = !rst && bus.fetch_en && !redirect &&
                     (({1'b0, inflight} + {1'b0, count}) < CREDITS);
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Responses during a redirect or while stale ones remain are discarded.
  assign push          = bus.imem_rsp_valid && !dropping && !redirect;
  assign push_dat.pc   = rsp_pc_q;
  assign push_dat.inst = bus.imem_rsp_data;

  assign bus.inst_valid     = !rst && !empty && !redirect;
  assign pop                = bus.inst_valid && bus.inst_ready;
  assign bus.inst           = (rst || empty) ? INST_W'(INST_NOP) : head.inst;
  assign bus.inst_pc        = (rst || empty) ? '0 : head.pc;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q[IMEM_AW+1:2];
  assign bus.misalign_err   = misalign_q;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  // PC, response tracking and stale-response accounting; redirect re-arms drop_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      rsp_pc_q   <= ADDR_W'(RESET_PC);
      inflight   <= '0;
      drop_cnt   <= '0;
      misalign_q <= 1'b0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (redirect) begin
        pc_q     <= target_pc;
        rsp_pc_q <= target_pc;
        drop_cnt <= inflight - CW'(bus.imem_rsp_valid);
        if (bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
      end else begin
        if (req_fire) pc_q     <= pc_q + STEP;
        if (push)     rsp_pc_q <= rsp_pc_q + STEP;
        if (bus.imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // A push into a full buffer would mean the credit check is broken.
  assert property (@(posedge clk) disable iff (rst) !(full && push && !pop));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed test of inst_fetch_unit against a latency-programmable memory model.
// Latency: n/a.
// Backpressure: memory ready is metered by a grant budget; decode stall driven directly.
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(32), .INST_W(32), .IMEM_AW(11)) bus ();

  inst_fetch_unit #(
    .ADDR_W(32), .INST_W(32), .IMEM_AW(11), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  int          lat = 1;
  int          grant_total = 0;
  int          accepted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d instructions still expected after 200 cycles", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // Memory model: in-order responses `lat` cycles after accept, data tagged with the word address.
  initial begin
    logic        fire;
    logic [10:0] faddr;
    logic [10:0] pend_addr [$];
    int          pend_due  [$];
    int          mem_cyc = 0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire  = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
      faddr = bus.imem_addr;
      @(posedge clk);
      mem_cyc++;
      #2;
      if (fire) begin
        pend_addr.push_back(faddr);
        pend_due.push_back(mem_cyc + lat - 1);
        accepted++;
      end
      if (pend_addr.size() != 0 && pend_due[0] <= mem_cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hA000_0000 | {21'b0, pend_addr[0]};
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      bus.imem_req_ready = (accepted < grant_total);
    end
  end

  // Scoreboard monitor: every decode hand-off must match the oldest expected PC.
  initial begin
    logic [31:0] pc;
    forever begin
      @(negedge clk);
      if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected delivery: inst_pc 0x%0h, nothing expected", bus.inst_pc);
        end else begin
          pc = exp_q.pop_front();
          check("inst_pc", bus.inst_pc, pc);
          check("inst", bus.inst, 32'hA000_0000 | ((pc >> 2) & 32'h7FF));
        end
      end
    end
  end

  initial begin
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst imem_addr", 32'(bus.imem_addr), 32'h0);
    check("rst inst", bus.inst, 32'h0);
    check("rst inst_pc", bus.inst_pc, 32'h0);
    check("rst misalign", 32'(bus.misalign_err), 32'h0);

    // Streaming with 1-cycle memory; first inst_valid two cycles after first accept.
    rst = 1'b0;
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    lat = 1;
    grant_total = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    tick();
    check("lat c1 inst_valid", 32'(bus.inst_valid), 32'h0);
    tick();
    check("lat c2 inst_valid", 32'(bus.inst_valid), 32'h1);
    wait_drain("stream");

    // Decode stall: only four requests may go out, then drain and resume.
    bus.inst_ready = 1'b0;
    grant_total = 12;
    repeat (8) tick();
    check("stall req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("stall accepted", 32'(accepted), 32'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h10 + 32'(i * 4));
    bus.inst_ready = 1'b1;
    wait_drain("stall release");

    // Redirect with three requests in flight.
    lat = 4;
    grant_total = grant_total + 3;
    repeat (3) tick();
    check("pre-redirect inflight", 32'(dut.inflight), 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    check("redirect drop_cnt", 32'(dut.drop_cnt), 32'd3);
    check("redirect imem_addr", 32'(bus.imem_addr), 32'h40);
    grant_total = grant_total + 2;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    wait_drain("redirect");

    // Redirect coinciding with a response.
    grant_total = grant_total + 3;
    repeat (4) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    check("same-cycle drop_cnt", 32'(dut.drop_cnt), 32'd2);
    check("same-cycle inflight", 32'(dut.inflight), 32'd2);
    grant_total = grant_total + 1;
    exp_q.push_back(32'h200);
    wait_drain("same-cycle redirect");

    // Misaligned redirect target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    check("misalign set", 32'(bus.misalign_err), 32'h1);
    grant_total = grant_total + 2;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    wait_drain("misalign");
    check("misalign sticky", 32'(bus.misalign_err), 32'h1);

    // Reset mid-stream with two in flight and two buffered.
    bus.inst_ready = 1'b0;
    lat = 4;
    grant_total = grant_total + 4;
    repeat (6) tick();
    check("pre-reset inflight", 32'(dut.inflight), 32'd2);
    rst = 1'b1;
    tick();
    check("reset inst_valid", 32'(bus.inst_valid), 32'h0);
    check("reset pc", dut.pc_q, 32'h0);
    check("reset imem_addr", 32'(bus.imem_addr), 32'h0);
    tick();
    rst = 1'b0;
    lat = 1;
    check("post-reset inflight", 32'(dut.inflight), 32'd0);
    check("post-reset inst_valid", 32'(bus.inst_valid), 32'h0);
    check("post-reset misalign", 32'(bus.misalign_err), 32'h0);
    grant_total = grant_total + 2;
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_drain("post-reset");
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
